exe_sideop_sequencer: RTL and testbench
=======================================

# exe_sideop_sequencer

Sequences the execute stage's side-effect requests onto the shared TLB and cache-maintenance ports: TLB check, single-entry TLB flush, INVD code, INVD data and WBINVD data. It sits between the execute command logic and the TLB/L1 control ports. It converts execute's level-held `*_do` requests into one req/ack transaction at a time and returns one-cycle `*_done` pulses. It also drains transactions that are still in flight when `exe_reset` flushes the pipeline.

## Interface
- No parameters.
- `clk` in 1 — core clock.
- `rst` in 1 — asynchronous, active-high reset.
- `exe_reset` in 1 — execute pipeline flush.
- `tlbcheck_do` in 1 — level request, held until `tlbcheck_done`.
- `tlbcheck_address` in 32 — linear address to check.
- `tlbcheck_rw` in 1 — 1 = write check.
- `tlbflushsingle_do` in 1 — level request.
- `tlbflushsingle_address` in 32 — address to flush.
- `invdcode_do` in 1 — level request.
- `invddata_do` in 1 — level request.
- `wbinvddata_do` in 1 — level request.
- `tlbcheck_done` out 1 — 1-cycle pulse.
- `tlbcheck_page_fault` out 1 — valid only while `tlbcheck_done`=1, else 0.
- `tlbflushsingle_done` out 1 — 1-cycle pulse.
- `invdcode_done` out 1 — 1-cycle pulse.
- `invddata_done` out 1 — 1-cycle pulse.
- `wbinvddata_done` out 1 — 1-cycle pulse.
- `tlb_req` out 1 — TLB port request, held until ack.
- `tlb_flush` out 1 — 0 = check, 1 = flush single.
- `tlb_address` out 32 — registered address.
- `tlb_rw` out 1 — registered rw; 0 for flush.
- `tlb_ack` in 1 — TLB completion.
- `tlb_page_fault` in 1 — qualified by `tlb_ack`.
- `cache_req` out 1 — cache port request, held until ack.
- `cache_op` out 2 — 0 = INVD code, 1 = INVD data, 2 = WBINVD data.
- `cache_ack` in 1 — cache completion.
- `busy` out 1 — state ≠ IDLE.

## Operation
- States:
  - IDLE
  - TLB_WAIT
  - CACHE_WAIT
  - DONE
  - DRAIN
- IDLE → issue when `exe_reset`=0 and any `*_do` is high.
  - Fixed priority: tlbcheck > tlbflushsingle > wbinvddata > invddata > invdcode.
  - Latch the winner in a 3-bit `op` register; latch address and rw.
  - Assert `tlb_req` or `cache_req`; go to TLB_WAIT or CACHE_WAIT.
- TLB_WAIT / CACHE_WAIT → on the matching ack:
  - Drop the request.
  - Latch `tlb_page_fault` (TLB check only).
  - Go to DONE, or to DRAIN if abort is set. DRAIN lasts 1 cycle, emits no done, then goes to IDLE.
- `exe_reset` high in any WAIT cycle sets a sticky abort flag; the request stays high until ack. Downstream transactions are never cancelled.
- DONE: assert the `*_done` selected by `op` for exactly 1 cycle, gated by `!exe_reset`; then go to IDLE.
  - The mandatory DONE → IDLE cycle guarantees execute has dropped `*_do` before IDLE samples again, so a request is never re-issued.
- A `*_do` that drops while WAIT is in progress has no effect; the transaction completes and its done is still pulsed unless aborted.
- Acks received in the wrong WAIT state, or in IDLE, are ignored.
- Latched address and rw do not change while `tlb_req`=1.
- Reset values: state = IDLE; all outputs 0; `op` = 0; abort = 0.
- Async `rst` mid-transaction returns to IDLE immediately. Downstream ports share `rst`, so no drain is required.

## Timing
- Request sampled in IDLE at cycle N → `tlb_req`/`cache_req` high at N+1 (registered).
- Ack at cycle M (M ≥ N+1) → request low and done pulse at M+1 → IDLE at M+2.
- Minimum do-to-done latency: 2 cycles. Next issue no earlier than M+2.
- Back-to-back requests: exactly 2 idle cycles on the port between transactions.
- Simultaneous `exe_reset` and ack in the same WAIT cycle → treated as aborted (DRAIN, no done).
- `exe_reset` in IDLE blocks issue that cycle only.

## Test plan
- TLB check: `tlbcheck_do`=1, address `0x0040_1000`, rw=1.
  - Response: `tlb_req` at N+1 with `tlb_address`=`0x0040_1000`, `tlb_rw`=1, `tlb_flush`=0.
  - Ack at N+3 with `tlb_page_fault`=1 → `tlbcheck_done`=1 and `tlbcheck_page_fault`=1 at N+4 only.
- Priority: `tlbflushsingle_do`, `wbinvddata_do` and `invdcode_do` raised together.
  - Response: issue order flush, then `cache_op`=2, then `cache_op`=0, each done exactly once.
- Zero-wait ack: ack tied high → `*_do` to done is exactly 2 cycles; port idle 2 cycles between transactions.
- Flush mid-wait: `exe_reset` pulsed in CACHE_WAIT, ack 5 cycles later.
  - Response: `cache_req` held until ack, no `invddata_done`, IDLE 2 cycles after ack.
- Async `rst` asserted in TLB_WAIT → all outputs 0 immediately; a request after release issues normally.
- Stray `tlb_ack` and `cache_ack` pulses in IDLE → no state change, no done.

Source files
------------

// File: rtl/exe_sideop_sequencer_if.sv
// Downstream side-effect ports of the execute stage: one TLB port and one
// cache-maintenance port, each a level request held until a completion ack.
interface exe_sideop_sequencer_if;
    logic        tlb_req;
    logic        tlb_flush;
    logic [31:0] tlb_address;
    logic        tlb_rw;
    logic        tlb_ack;
    logic        tlb_page_fault;
    logic        cache_req;
    logic [1:0]  cache_op;
    logic        cache_ack;

    modport master (
        output tlb_req, tlb_flush, tlb_address, tlb_rw,
        input  tlb_ack, tlb_page_fault,
        output cache_req, cache_op,
        input  cache_ack
    );

    modport slave (
        input  tlb_req, tlb_flush, tlb_address, tlb_rw,
        output tlb_ack, tlb_page_fault,
        input  cache_req, cache_op,
        output cache_ack
    );
endinterface

// File: rtl/exe_sideop_sequencer.sv
// Serialises execute's level-held side-effect requests into one TLB/cache
// req/ack transaction at a time and returns one-cycle done pulses.
module exe_sideop_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_reset,
    input  logic        tlbcheck_do,
    input  logic [31:0] tlbcheck_address,
    input  logic        tlbcheck_rw,
    input  logic        tlbflushsingle_do,
    input  logic [31:0] tlbflushsingle_address,
    input  logic        invdcode_do,
    input  logic        invddata_do,
    input  logic        wbinvddata_do,
    output logic        tlbcheck_done,
    output logic        tlbcheck_page_fault,
    output logic        tlbflushsingle_done,
    output logic        invdcode_done,
    output logic        invddata_done,
    output logic        wbinvddata_done,
    output logic        busy,
    exe_sideop_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TLB_WAIT   = 3'd1,
        ST_CACHE_WAIT = 3'd2,
        ST_DONE       = 3'd3,
        ST_DRAIN      = 3'd4
    } state_t;

    localparam logic [2:0] OP_TLBCHECK = 3'd0;
    localparam logic [2:0] OP_TLBFLUSH = 3'd1;
    localparam logic [2:0] OP_WBINVD   = 3'd2;
    localparam logic [2:0] OP_INVDDATA = 3'd3;
    localparam logic [2:0] OP_INVDCODE = 3'd4;

    state_t      state_r;
    logic [2:0]  op_r;
    logic        abort_r;
    logic [4:0]  done_r;
    logic        fault_r;
    logic [2:0]  sel_op_s;
    logic        sel_valid_s;
    logic        sel_is_tlb_s;

    function automatic logic [1:0] cache_op_of(input logic [2:0] op);
        case (op)
            OP_INVDCODE: cache_op_of = 2'd0;
            OP_INVDDATA: cache_op_of = 2'd1;
            OP_WBINVD:   cache_op_of = 2'd2;
            default:     cache_op_of = 2'd0;
        endcase
    endfunction

    // Bit order: tlbcheck, tlbflushsingle, wbinvddata, invddata, invdcode.
    function automatic logic [4:0] done_onehot(input logic [2:0] op);
        case (op)
            OP_TLBCHECK: done_onehot = 5'b00001;
            OP_TLBFLUSH: done_onehot = 5'b00010;
            OP_WBINVD:   done_onehot = 5'b00100;
            OP_INVDDATA: done_onehot = 5'b01000;
            OP_INVDCODE: done_onehot = 5'b10000;
            default:     done_onehot = 5'b00000;
        endcase
    endfunction

    // Fixed-priority pick among the pending requests.
    always_comb begin
        sel_op_s    = OP_INVDCODE;
        sel_valid_s = tlbcheck_do | tlbflushsingle_do | wbinvddata_do |
                      invddata_do | invdcode_do;
        if (tlbcheck_do) begin
            sel_op_s = OP_TLBCHECK;
        end else if (tlbflushsingle_do) begin
            sel_op_s = OP_TLBFLUSH;
        end else if (wbinvddata_do) begin
            sel_op_s = OP_WBINVD;
        end else if (invddata_do) begin
            sel_op_s = OP_INVDDATA;
        end else begin
            sel_op_s = OP_INVDCODE;
        end
        sel_is_tlb_s = (sel_op_s == OP_TLBCHECK) || (sel_op_s == OP_TLBFLUSH);
    end

    // Transaction sequencer; all port outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            op_r            <= 3'd0;
            abort_r         <= 1'b0;
            done_r          <= 5'b00000;
            fault_r         <= 1'b0;
            bus.tlb_req     <= 1'b0;
            bus.tlb_flush   <= 1'b0;
            bus.tlb_address <= 32'd0;
            bus.tlb_rw      <= 1'b0;
            bus.cache_req   <= 1'b0;
            bus.cache_op    <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!exe_reset && sel_valid_s) begin
                        op_r    <= sel_op_s;
                        abort_r <= 1'b0;
                        if (sel_is_tlb_s) begin
                            bus.tlb_req     <= 1'b1;
                            bus.tlb_flush   <= (sel_op_s == OP_TLBFLUSH);
                            bus.tlb_address <= (sel_op_s == OP_TLBCHECK) ?
                                               tlbcheck_address : tlbflushsingle_address;
                            bus.tlb_rw      <= (sel_op_s == OP_TLBCHECK) ? tlbcheck_rw : 1'b0;
                            state_r         <= ST_TLB_WAIT;
                        end else begin
                            bus.cache_req <= 1'b1;
                            bus.cache_op  <= cache_op_of(sel_op_s);
                            state_r       <= ST_CACHE_WAIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_TLB_WAIT: begin
                    if (bus.tlb_ack) begin
                        bus.tlb_req <= 1'b0;
                        fault_r     <= bus.tlb_page_fault && (op_r == OP_TLBCHECK);
                        abort_r     <= 1'b0;
                        if (abort_r || exe_reset) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            done_r  <= done_onehot(op_r);
                            state_r <= ST_DONE;
                        end
                    end else begin
                        abort_r <= abort_r | exe_reset;
                    end
                end
                ST_CACHE_WAIT: begin
                    if (bus.cache_ack) begin
                        bus.cache_req <= 1'b0;
                        abort_r       <= 1'b0;
                        if (abort_r || exe_reset) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            done_r  <= done_onehot(op_r);
                            state_r <= ST_DONE;
                        end
                    end else begin
                        abort_r <= abort_r | exe_reset;
                    end
                end
                ST_DONE: begin
                    done_r  <= 5'b00000;
                    fault_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_DRAIN: begin
                    fault_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 5'b00000;
                    abort_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // A flush arriving in the done cycle suppresses the pulse.
    assign tlbcheck_done       = done_r[0] & ~exe_reset;
    assign tlbflushsingle_done = done_r[1] & ~exe_reset;
    assign wbinvddata_done     = done_r[2] & ~exe_reset;
    assign invddata_done       = done_r[3] & ~exe_reset;
    assign invdcode_done       = done_r[4] & ~exe_reset;
    assign tlbcheck_page_fault = tlbcheck_done & fault_r;
    assign busy                = (state_r != ST_IDLE);

endmodule

// File: tb/tb_exe_sideop_sequencer.sv
// Directed bench for exe_sideop_sequencer with a queue-based scoreboard:
// stimulus pushes expected port events, a negedge monitor pops and compares.
module tb_exe_sideop_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_reset;
    logic        tlbcheck_do;
    logic [31:0] tlbcheck_address;
    logic        tlbcheck_rw;
    logic        tlbflushsingle_do;
    logic [31:0] tlbflushsingle_address;
    logic        invdcode_do;
    logic        invddata_do;
    logic        wbinvddata_do;
    logic        tlbcheck_done;
    logic        tlbcheck_page_fault;
    logic        tlbflushsingle_done;
    logic        invdcode_done;
    logic        invddata_done;
    logic        wbinvddata_done;
    logic        busy;

    exe_sideop_sequencer_if bus();

    exe_sideop_sequencer dut (
        .clk                    (clk),
        .rst                    (rst),
        .exe_reset              (exe_reset),
        .tlbcheck_do            (tlbcheck_do),
        .tlbcheck_address       (tlbcheck_address),
        .tlbcheck_rw            (tlbcheck_rw),
        .tlbflushsingle_do      (tlbflushsingle_do),
        .tlbflushsingle_address (tlbflushsingle_address),
        .invdcode_do            (invdcode_do),
        .invddata_do            (invddata_do),
        .wbinvddata_do          (wbinvddata_do),
        .tlbcheck_done          (tlbcheck_done),
        .tlbcheck_page_fault    (tlbcheck_page_fault),
        .tlbflushsingle_done    (tlbflushsingle_done),
        .invdcode_done          (invdcode_done),
        .invddata_done          (invddata_done),
        .wbinvddata_done        (wbinvddata_done),
        .busy                   (busy),
        .bus                    (bus.master)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] K_TLB   = 2'd1;
    localparam logic [1:0] K_CACHE = 2'd2;
    localparam logic [1:0] K_DONE  = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic        rw;
        logic        flush;
        logic [1:0]  cop;
        logic [4:0]  dv;
        logic        pf;
        logic [15:0] cyc;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    logic prev_tlb_req = 1'b0;
    logic prev_cache_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t ev_tlb(input logic [31:0] a, input logic rw, input logic fl, input int c);
        ev_t e = '0;
        e.kind = K_TLB; e.addr = a; e.rw = rw; e.flush = fl; e.cyc = 16'(c);
        return e;
    endfunction

    function automatic ev_t ev_cache(input logic [1:0] op, input int c);
        ev_t e = '0;
        e.kind = K_CACHE; e.cop = op; e.cyc = 16'(c);
        return e;
    endfunction

    function automatic ev_t ev_done(input logic [4:0] dv, input logic pf, input int c);
        ev_t e = '0;
        e.kind = K_DONE; e.dv = dv; e.pf = pf; e.cyc = 16'(c);
        return e;
    endfunction

    task automatic observe(input ev_t got);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d data=%h, required no event",
                     got.kind, got.cyc, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL event: got kind=%0d cyc=%0d data=%h, required kind=%0d cyc=%0d data=%h",
                         got.kind, got.cyc, got, e.kind, e.cyc, e);
            end
        end
    endtask

    // Monitor: turns port activity into events and checks them against the queue.
    always @(negedge clk) begin
        ev_t  got;
        logic [4:0] dv;
        if (!rst) begin
            if (bus.tlb_req && !prev_tlb_req) begin
                got = ev_tlb(bus.tlb_address, bus.tlb_rw, bus.tlb_flush, cyc);
                observe(got);
            end
            if (bus.cache_req && !prev_cache_req) begin
                got = ev_cache(bus.cache_op, cyc);
                observe(got);
            end
            dv = {invdcode_done, invddata_done, wbinvddata_done, tlbflushsingle_done, tlbcheck_done};
            if (dv != 5'b00000 || tlbcheck_page_fault) begin
                got = ev_done(dv, tlbcheck_page_fault, cyc);
                observe(got);
            end
        end
        prev_tlb_req   = bus.tlb_req;
        prev_cache_req = bus.cache_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bit drained;
        rst = 1'b1; exe_reset = 1'b0;
        tlbcheck_do = 1'b0; tlbcheck_address = 32'd0; tlbcheck_rw = 1'b0;
        tlbflushsingle_do = 1'b0; tlbflushsingle_address = 32'd0;
        invdcode_do = 1'b0; invddata_do = 1'b0; wbinvddata_do = 1'b0;
        bus.tlb_ack = 1'b0; bus.tlb_page_fault = 1'b0; bus.cache_ack = 1'b0;

        // Reset state
        repeat (2) step();
        chk("rst_tlb_req", 32'(bus.tlb_req), 32'd0);
        chk("rst_cache_req", 32'(bus.cache_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tlb_address", bus.tlb_address, 32'd0);
        chk("rst_cache_op", 32'(bus.cache_op), 32'd0);
        chk("rst_dones", 32'({tlbcheck_done, tlbflushsingle_done, invdcode_done, invddata_done,
                              wbinvddata_done, tlbcheck_page_fault}), 32'd0);
        rst = 1'b0;
        step();

        // TLB check with page fault, ack two cycles after the request
        c = cyc;
        tlbcheck_do = 1'b1; tlbcheck_address = 32'h0040_1000; tlbcheck_rw = 1'b1;
        exp_q.push_back(ev_tlb(32'h0040_1000, 1'b1, 1'b0, c + 1));
        step();
        chk("t1_req", 32'(bus.tlb_req), 32'd1);
        step();
        tlbcheck_address = 32'hDEAD_0000;
        step();
        chk("t1_addr_stable", bus.tlb_address, 32'h0040_1000);
        bus.tlb_ack = 1'b1; bus.tlb_page_fault = 1'b1;
        exp_q.push_back(ev_done(5'b00001, 1'b1, c + 4));
        step();
        bus.tlb_ack = 1'b0; bus.tlb_page_fault = 1'b0; tlbcheck_do = 1'b0;
        chk("t1_req_dropped", 32'(bus.tlb_req), 32'd0);
        step();
        chk("t1_pf_cleared", 32'(tlbcheck_page_fault), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // Priority with both acks tied high: flush, then WBINVD, then INVD code
        step();
        c = cyc;
        bus.tlb_ack = 1'b1; bus.cache_ack = 1'b1;
        tlbflushsingle_do = 1'b1; tlbflushsingle_address = 32'h1234_5000;
        wbinvddata_do = 1'b1; invdcode_do = 1'b1;
        exp_q.push_back(ev_tlb(32'h1234_5000, 1'b0, 1'b1, c + 1));
        exp_q.push_back(ev_done(5'b00010, 1'b0, c + 2));
        exp_q.push_back(ev_cache(2'd2, c + 4));
        exp_q.push_back(ev_done(5'b00100, 1'b0, c + 5));
        exp_q.push_back(ev_cache(2'd0, c + 7));
        exp_q.push_back(ev_done(5'b10000, 1'b0, c + 8));
        drained = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tlbflushsingle_done) tlbflushsingle_do = 1'b0;
            if (wbinvddata_done) wbinvddata_do = 1'b0;
            if (invdcode_done) invdcode_do = 1'b0;
            if (!tlbflushsingle_do && !wbinvddata_do && !invdcode_do && !busy) begin
                drained = 1'b1;
                break;
            end
        end
        chk("t2_drained_in_budget", 32'(drained), 32'd1);
        bus.tlb_ack = 1'b0; bus.cache_ack = 1'b0;
        tlbflushsingle_do = 1'b0; wbinvddata_do = 1'b0; invdcode_do = 1'b0;

        // Flush mid CACHE_WAIT: request held, no done, drain then idle
        step();
        c = cyc;
        invddata_do = 1'b1;
        exp_q.push_back(ev_cache(2'd1, c + 1));
        step();
        step();
        exe_reset = 1'b1;
        step();
        exe_reset = 1'b0; invddata_do = 1'b0;
        repeat (3) step();
        chk("t3_req_held", 32'(bus.cache_req), 32'd1);
        step();
        bus.cache_ack = 1'b1;
        step();
        bus.cache_ack = 1'b0;
        chk("t3_req_dropped", 32'(bus.cache_req), 32'd0);
        chk("t3_drain_busy", 32'(busy), 32'd1);
        chk("t3_no_done", 32'(invddata_done), 32'd0);
        step();
        chk("t3_idle", 32'(busy), 32'd0);

        // exe_reset coincident with ack: aborted, no done
        step();
        c = cyc;
        tlbflushsingle_do = 1'b1; tlbflushsingle_address = 32'h0000_7000;
        exp_q.push_back(ev_tlb(32'h0000_7000, 1'b0, 1'b1, c + 1));
        step();
        bus.tlb_ack = 1'b1; exe_reset = 1'b1; tlbflushsingle_do = 1'b0;
        step();
        bus.tlb_ack = 1'b0; exe_reset = 1'b0;
        chk("t4_drain_busy", 32'(busy), 32'd1);
        chk("t4_no_done", 32'(tlbflushsingle_done), 32'd0);
        step();
        chk("t4_idle", 32'(busy), 32'd0);

        // exe_reset during the done cycle suppresses the pulse
        step();
        c = cyc;
        invdcode_do = 1'b1;
        exp_q.push_back(ev_cache(2'd0, c + 1));
        step();
        bus.cache_ack = 1'b1;
        step();
        bus.cache_ack = 1'b0; exe_reset = 1'b1; invdcode_do = 1'b0;
        #1;
        chk("t5_done_gated", 32'(invdcode_done), 32'd0);
        step();
        exe_reset = 1'b0;
        chk("t5_idle", 32'(busy), 32'd0);

        // exe_reset in IDLE blocks issue for that cycle only
        step();
        c = cyc;
        exe_reset = 1'b1; invddata_do = 1'b1;
        step();
        exe_reset = 1'b0;
        chk("t6_blocked", 32'(bus.cache_req), 32'd0);
        exp_q.push_back(ev_cache(2'd1, c + 2));
        step();
        step();
        bus.cache_ack = 1'b1;
        exp_q.push_back(ev_done(5'b01000, 1'b0, c + 4));
        step();
        bus.cache_ack = 1'b0; invddata_do = 1'b0;
        step();

        // Async rst in TLB_WAIT, then a normal request after release
        step();
        c = cyc;
        tlbcheck_do = 1'b1; tlbcheck_address = 32'h8000_0004; tlbcheck_rw = 1'b0;
        exp_q.push_back(ev_tlb(32'h8000_0004, 1'b0, 1'b0, c + 1));
        step();
        step();
        rst = 1'b1;
        #1;
        chk("t7_rst_tlb_req", 32'(bus.tlb_req), 32'd0);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        chk("t7_rst_addr", bus.tlb_address, 32'd0);
        tlbcheck_do = 1'b0;
        rst = 1'b0;
        step();
        c = cyc;
        tlbcheck_do = 1'b1; tlbcheck_address = 32'h0000_2008; tlbcheck_rw = 1'b1;
        exp_q.push_back(ev_tlb(32'h0000_2008, 1'b1, 1'b0, c + 1));
        step();
        bus.tlb_ack = 1'b1; bus.tlb_page_fault = 1'b0;
        exp_q.push_back(ev_done(5'b00001, 1'b0, c + 2));
        step();
        bus.tlb_ack = 1'b0; tlbcheck_do = 1'b0;
        step();

        // Stray acks in IDLE are ignored
        step();
        bus.tlb_ack = 1'b1; bus.tlb_page_fault = 1'b1;
        step();
        bus.tlb_ack = 1'b0; bus.tlb_page_fault = 1'b0; bus.cache_ack = 1'b1;
        chk("t8_busy_a", 32'(busy), 32'd0);
        step();
        bus.cache_ack = 1'b0;
        chk("t8_busy_b", 32'(busy), 32'd0);
        chk("t8_no_req", 32'({bus.tlb_req, bus.cache_req}), 32'd0);
        step();
        chk("t8_busy_c", 32'(busy), 32'd0);

        repeat (3) step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
